// File: rtl/uart_rx_deser_pkg.sv
// uart_rx_deser_pkg: receiver state encoding and default timing shared with the uart_tx side
package uart_rx_deser_pkg;
  localparam int CLK_DIV_DEF = 27;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF = 8;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
endpackage

// File: rtl/uart_rx_deser_baud_tick.sv
// uart_rx_deser_baud_tick: free-running divider giving one oversample tick every CLK_DIV clocks
module uart_rx_deser_baud_tick
  import uart_rx_deser_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  logic [CW-1:0] r_cnt;
  assign o_tick = r_cnt == LAST;
  always_ff @(posedge i_clk)
    r_cnt <= (i_reset || o_tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: oversampling 8N1 receiver with valid/ready output and framing/overrun pulses
module uart_rx_deser
  import uart_rx_deser_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_frame_err,
  output logic                 o_overrun_err,
  output logic                 o_busy,
  input  logic                 i_scan_in0,
  input  logic                 i_scan_enable,
  input  logic                 i_test_mode,
  output logic                 o_scan_out0
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] SC_MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SC_END = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BC_END = BW'(DATA_BITS - 1);
  logic [1:0]           r_sync;
  state_t               r_state;
  logic [SW-1:0]        r_sc;
  logic [BW-1:0]        r_bc;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 w_tick;
  logic                 w_rxd_s;
  logic                 w_unused;
  uart_rx_deser_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_tick  (w_tick)
  );
  assign w_rxd_s     = r_sync[1];
  assign o_busy      = r_state != S_IDLE;
  assign o_scan_out0 = 1'b0;
  assign w_unused    = ^{i_scan_in0, i_scan_enable, i_test_mode};
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync        <= 2'b11;
      r_state       <= S_IDLE;
      r_sc          <= '0;
      r_bc          <= '0;
      r_shreg       <= '0;
      o_rx_data     <= '0;
      o_rx_valid    <= 1'b0;
      o_frame_err   <= 1'b0;
      o_overrun_err <= 1'b0;
    end else begin
      r_sync        <= {r_sync[0], i_rxd};
      o_frame_err   <= 1'b0;
      o_overrun_err <= 1'b0;
      if (o_rx_valid && i_rx_ready) o_rx_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_IDLE: if (!w_rxd_s) begin
            r_state <= S_START;
            r_sc    <= '0;
          end
          S_START: if (r_sc == SC_MID) begin
            r_state <= w_rxd_s ? S_IDLE : S_DATA;
            r_sc    <= '0;
            r_bc    <= '0;
          end else r_sc <= r_sc + 1'b1;
          S_DATA: if (r_sc == SC_END) begin
            r_shreg <= {w_rxd_s, r_shreg[DATA_BITS-1:1]};
            r_sc    <= '0;
            r_bc    <= r_bc + 1'b1;
            if (r_bc == BC_END) r_state <= S_STOP;
          end else r_sc <= r_sc + 1'b1;
          S_STOP: if (r_sc == SC_END) begin
            r_sc <= '0;
            if (!w_rxd_s) begin
              o_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end else begin
              r_state <= S_IDLE;
              // a byte accepted on this same edge frees the holding register
              if (!o_rx_valid || i_rx_ready) begin
                o_rx_data  <= r_shreg;
                o_rx_valid <= 1'b1;
              end else o_overrun_err <= 1'b1;
            end
          end else r_sc <= r_sc + 1'b1;
          S_BREAK: if (w_rxd_s) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
